frame_sequencer: RTL and testbench

Parametrised frame-level draw sequencer sitting between the frame-rate pulse source and the `draw` engine / SDRAM interface. Per frame it:
- optionally clears the back buffer;
- walks a primitive list of up to MAX_PRIMS entries, issuing each to `draw` and waiting for completion;
- optionally waits for vertical blank;
- swaps buffers.

It generalises the fixed single-triangle, double-buffer loop to N buffers, a variable-length primitive list and selectable clear/vsync modes.

---
 rtl/fgpa_draw_pkg.sv | 25 ++
 rtl/frame_sequencer_buffer_rotator.sv | 42 ++++
 rtl/frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fgpa_draw_pkg.sv
// Shared definitions for the frame-level draw path: draw opcodes, the
// sequencer state encoding and the default frame buffer geometry.
package fgpa_draw_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BYTES_PER_PIXEL = 4;

    localparam logic [31:0] DEFAULT_BUF_SIZE = 32'(SCREEN_W * SCREEN_H * BYTES_PER_PIXEL);

    localparam logic [3:0] OP_CLEAR    = 4'd0;
    localparam logic [3:0] OP_TRIANGLE = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_ISSUE,
        ST_CLR_WAIT,
        ST_FETCH,
        ST_PRIM_ISSUE,
        ST_PRIM_WAIT,
        ST_BLANK_WAIT,
        ST_SWAP
    } fsm_state_e;

endpackage

// File: rtl/frame_sequencer_buffer_rotator.sv
// Frame buffer rotation: tracks displayed/back buffer indices and the SDRAM
// base address of the back buffer.
module buffer_rotator #(
    parameter int          NUM_BUFFERS = 2,
    parameter logic [31:0] BUF_BASE    = 32'h0000_0000,
    parameter logic [31:0] BUF_SIZE    = 32'h0012_C000
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        swap_i,
    output logic [1:0]  front_idx_o,
    output logic [31:0] back_buf_addr_o
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_BUFFERS - 1);

    logic [1:0]  front_idx_q;
    logic [1:0]  back_idx_q;
    logic [1:0]  back_idx_d;
    logic [31:0] back_addr_q;
    logic [31:0] back_addr_d;

    assign back_idx_d  = (back_idx_q == LAST_IDX) ? 2'd0 : back_idx_q + 2'd1;
    // Address is computed from the next index so it lands together with the swap.
    assign back_addr_d = BUF_BASE + ({30'd0, back_idx_d} * BUF_SIZE);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            front_idx_q <= 2'd0;
            back_idx_q  <= 2'd1;
            back_addr_q <= BUF_BASE + BUF_SIZE;
        end else if (swap_i) begin
            front_idx_q <= back_idx_q;
            back_idx_q  <= back_idx_d;
            back_addr_q <= back_addr_d;
        end
    end

    assign front_idx_o     = front_idx_q;
    assign back_buf_addr_o = back_addr_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame draw sequencer: optional clear, primitive list walk, optional
// vblank wait, then buffer swap across NUM_BUFFERS frame buffers.
module frame_sequencer
    import fgpa_draw_pkg::*;
#(
    parameter int          COORD_W     = 16,
    parameter int          COLOUR_W    = 32,
    parameter int          NUM_BUFFERS = 2,
    parameter logic [31:0] BUF_BASE    = 32'h0000_0000,
    parameter logic [31:0] BUF_SIZE    = DEFAULT_BUF_SIZE,
    parameter int          MAX_PRIMS   = 16,
    localparam int         IDX_W       = $clog2(MAX_PRIMS)
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                clear_en,
    input  logic [COLOUR_W-1:0] clear_colour,
    input  logic                vsync_swap,
    input  logic [IDX_W:0]      prim_count,
    output logic [IDX_W-1:0]    prim_idx,
    input  logic [3:0]          prim_opcode,
    input  logic [COORD_W-1:0]  prim_ax,
    input  logic [COORD_W-1:0]  prim_ay,
    input  logic [COORD_W-1:0]  prim_bx,
    input  logic [COORD_W-1:0]  prim_by,
    input  logic [COORD_W-1:0]  prim_cx,
    input  logic [COORD_W-1:0]  prim_cy,
    input  logic [COLOUR_W-1:0] prim_colour,
    input  logic                vga_blank_n,
    input  logic                draw_done,
    output logic                draw_en,
    output logic [3:0]          opcode,
    output logic [COORD_W-1:0]  ax,
    output logic [COORD_W-1:0]  ay,
    output logic [COORD_W-1:0]  bx,
    output logic [COORD_W-1:0]  by,
    output logic [COORD_W-1:0]  cx,
    output logic [COORD_W-1:0]  cy,
    output logic [COLOUR_W-1:0] colour,
    output logic                screen_clear,
    output logic                swap_buffer,
    output logic [31:0]         back_buf_addr,
    output logic [1:0]          front_idx,
    output logic                busy,
    output logic                frame_dropped,
    output logic [15:0]         frame_count
);

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_PRIMS);
    localparam logic [IDX_W:0] ONE_CNT = (IDX_W + 1)'(1);

    fsm_state_e          state_q;
    logic [IDX_W:0]      count_q;
    logic                vsync_q;
    logic [COLOUR_W-1:0] clear_colour_q;
    logic [IDX_W-1:0]    prim_idx_q;
    logic                draw_en_q;
    logic                screen_clear_q;
    logic                swap_q;
    logic                frame_dropped_q;
    logic [15:0]         frame_count_q;
    logic [3:0]          opcode_q;
    logic [COORD_W-1:0]  ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [COLOUR_W-1:0] colour_q;

    logic [IDX_W:0]      sat_count;
    logic [IDX_W:0]      idx_plus1;
    fsm_state_e          tail_state;

    assign sat_count  = (prim_count > MAX_CNT) ? MAX_CNT : prim_count;
    assign idx_plus1  = {1'b0, prim_idx_q} + ONE_CNT;
    assign tail_state = vsync_q ? ST_BLANK_WAIT : ST_SWAP;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            vsync_q         <= 1'b0;
            clear_colour_q  <= '0;
            prim_idx_q      <= '0;
            draw_en_q       <= 1'b0;
            screen_clear_q  <= 1'b0;
            swap_q          <= 1'b0;
            frame_dropped_q <= 1'b0;
            frame_count_q   <= '0;
            opcode_q        <= OP_CLEAR;
            ax_q            <= '0;
            ay_q            <= '0;
            bx_q            <= '0;
            by_q            <= '0;
            cx_q            <= '0;
            cy_q            <= '0;
            colour_q        <= '0;
        end else begin
            draw_en_q       <= 1'b0;
            screen_clear_q  <= 1'b0;
            swap_q          <= 1'b0;
            frame_dropped_q <= frame_start && (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        count_q        <= sat_count;
                        vsync_q        <= vsync_swap;
                        clear_colour_q <= clear_colour;
                        prim_idx_q     <= '0;
                        if (clear_en)
                            state_q <= ST_CLR_ISSUE;
                        else if (sat_count != '0)
                            state_q <= ST_FETCH;
                        else
                            state_q <= vsync_swap ? ST_BLANK_WAIT : ST_SWAP;
                    end
                end
                ST_CLR_ISSUE: begin
                    draw_en_q      <= 1'b1;
                    screen_clear_q <= 1'b1;
                    opcode_q       <= OP_CLEAR;
                    ax_q           <= '0;
                    ay_q           <= '0;
                    bx_q           <= '0;
                    by_q           <= '0;
                    cx_q           <= '0;
                    cy_q           <= '0;
                    colour_q       <= clear_colour_q;
                    state_q        <= ST_CLR_WAIT;
                end
                // draw_done in the same cycle as the strobe is too early to belong to it.
                ST_CLR_WAIT: begin
                    if (draw_done && !draw_en_q)
                        state_q <= (count_q != '0) ? ST_FETCH : tail_state;
                end
                ST_FETCH: begin
                    state_q <= ST_PRIM_ISSUE;
                end
                ST_PRIM_ISSUE: begin
                    draw_en_q <= 1'b1;
                    opcode_q  <= prim_opcode;
                    ax_q      <= prim_ax;
                    ay_q      <= prim_ay;
                    bx_q      <= prim_bx;
                    by_q      <= prim_by;
                    cx_q      <= prim_cx;
                    cy_q      <= prim_cy;
                    colour_q  <= prim_colour;
                    state_q   <= ST_PRIM_WAIT;
                end
                ST_PRIM_WAIT: begin
                    if (draw_done && !draw_en_q) begin
                        if (idx_plus1 < count_q) begin
                            prim_idx_q <= idx_plus1[IDX_W-1:0];
                            state_q    <= ST_FETCH;
                        end else begin
                            state_q <= tail_state;
                        end
                    end
                end
                ST_BLANK_WAIT: begin
                    if (!vga_blank_n)
                        state_q <= ST_SWAP;
                end
                ST_SWAP: begin
                    swap_q        <= 1'b1;
                    frame_count_q <= frame_count_q + 16'd1;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    buffer_rotator #(
        .NUM_BUFFERS (NUM_BUFFERS),
        .BUF_BASE    (BUF_BASE),
        .BUF_SIZE    (BUF_SIZE)
    ) u_rotator (
        .sys_clk         (sys_clk),
        .reset           (reset),
        .swap_i          (state_q == ST_SWAP),
        .front_idx_o     (front_idx),
        .back_buf_addr_o (back_buf_addr)
    );

    assign prim_idx      = prim_idx_q;
    assign draw_en       = draw_en_q;
    assign screen_clear  = screen_clear_q;
    assign swap_buffer   = swap_q;
    assign frame_dropped = frame_dropped_q;
    assign frame_count   = frame_count_q;
    assign busy          = (state_q != ST_IDLE);
    assign opcode        = opcode_q;
    assign ax            = ax_q;
    assign ay            = ay_q;
    assign bx            = bx_q;
    assign by            = by_q;
    assign cx            = cx_q;
    assign cy            = cy_q;
    assign colour        = colour_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a double-buffered instance for the frame
// flow scenarios and a triple-buffered instance for buffer rotation.
module tb_frame_sequencer;
    import fgpa_draw_pkg::*;

    localparam int CW = 16;
    localparam int LW = 32;
    localparam int IW = 4;
    localparam int DONE_DLY = 5;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic          reset, frame_start, frame_start_3, clear_en, vsync_swap, vga_blank_n, draw_done;
    logic [LW-1:0] clear_colour;
    logic [IW:0]   prim_count;
    logic [IW-1:0] prim_idx, prim_idx_3;
    logic [3:0]    prim_opcode;
    logic [CW-1:0] prim_ax, prim_ay, prim_bx, prim_by, prim_cx, prim_cy;
    logic [LW-1:0] prim_colour;

    logic          draw_en, screen_clear, swap_buffer, busy, frame_dropped;
    logic [3:0]    opcode;
    logic [CW-1:0] ax, ay, bx, by, cx, cy;
    logic [LW-1:0] colour;
    logic [31:0]   back_buf_addr;
    logic [1:0]    front_idx;
    logic [15:0]   frame_count;

    logic          draw_en_3, screen_clear_3, swap_buffer_3, busy_3, frame_dropped_3;
    logic [3:0]    opcode_3;
    logic [CW-1:0] ax_3, ay_3, bx_3, by_3, cx_3, cy_3;
    logic [LW-1:0] colour_3;
    logic [31:0]   back_buf_addr_3;
    logic [1:0]    front_idx_3;
    logic [15:0]   frame_count_3;

    frame_sequencer #(.NUM_BUFFERS(2)) u_dut (
        .sys_clk(sys_clk), .reset(reset), .frame_start(frame_start),
        .clear_en(clear_en), .clear_colour(clear_colour), .vsync_swap(vsync_swap),
        .prim_count(prim_count), .prim_idx(prim_idx), .prim_opcode(prim_opcode),
        .prim_ax(prim_ax), .prim_ay(prim_ay), .prim_bx(prim_bx), .prim_by(prim_by),
        .prim_cx(prim_cx), .prim_cy(prim_cy), .prim_colour(prim_colour),
        .vga_blank_n(vga_blank_n), .draw_done(draw_done), .draw_en(draw_en),
        .opcode(opcode), .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .colour(colour), .screen_clear(screen_clear), .swap_buffer(swap_buffer),
        .back_buf_addr(back_buf_addr), .front_idx(front_idx), .busy(busy),
        .frame_dropped(frame_dropped), .frame_count(frame_count)
    );

    frame_sequencer #(.NUM_BUFFERS(3)) u_dut3 (
        .sys_clk(sys_clk), .reset(reset), .frame_start(frame_start_3),
        .clear_en(clear_en), .clear_colour(clear_colour), .vsync_swap(vsync_swap),
        .prim_count(prim_count), .prim_idx(prim_idx_3), .prim_opcode(prim_opcode),
        .prim_ax(prim_ax), .prim_ay(prim_ay), .prim_bx(prim_bx), .prim_by(prim_by),
        .prim_cx(prim_cx), .prim_cy(prim_cy), .prim_colour(prim_colour),
        .vga_blank_n(vga_blank_n), .draw_done(draw_done), .draw_en(draw_en_3),
        .opcode(opcode_3), .ax(ax_3), .ay(ay_3), .bx(bx_3), .by(by_3), .cx(cx_3), .cy(cy_3),
        .colour(colour_3), .screen_clear(screen_clear_3), .swap_buffer(swap_buffer_3),
        .back_buf_addr(back_buf_addr_3), .front_idx(front_idx_3), .busy(busy_3),
        .frame_dropped(frame_dropped_3), .frame_count(frame_count_3)
    );

    // Primitive list with one-cycle registered read; contents derived from the index.
    always @(posedge sys_clk) begin
        prim_opcode <= OP_TRIANGLE;
        prim_ax     <= 16'h0100 + {12'h000, prim_idx};
        prim_ay     <= 16'h0200 + {12'h000, prim_idx};
        prim_bx     <= 16'h0300 + {12'h000, prim_idx};
        prim_by     <= 16'h0400 + {12'h000, prim_idx};
        prim_cx     <= 16'h0500 + {12'h000, prim_idx};
        prim_cy     <= 16'h0600 + {12'h000, prim_idx};
        prim_colour <= 32'hC0DE_0000 | {28'h0, prim_idx};
    end

    int checks = 0;
    int errors = 0;

    int          n_en, swap_tick, swap_cnt, drop_cnt;
    bit          timed_out;
    logic [3:0]  en_op  [4];
    logic        en_clr [4];
    logic [31:0] en_col [4];
    logic [15:0] en_ax  [4];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Runs one frame from the current (post-edge) point; tick numbers are relative
    // to the frame_start cycle (tick 0). Inputs driven after tick t are seen at edge t+1.
    task automatic run_frame(input int blank_tick, input int inj_a, input int inj_b,
                             input int spur_tick);
        int cd;
        n_en = 0; swap_tick = -1; swap_cnt = 0; drop_cnt = 0; cd = 0;
        frame_start = 1'b1;
        draw_done   = 1'b0;
        vga_blank_n = (blank_tick > 0);
        for (int t = 1; t < 200; t++) begin
            tick();
            if (draw_en) begin
                if (n_en < 4) begin
                    en_op[n_en]  = opcode;
                    en_clr[n_en] = screen_clear;
                    en_col[n_en] = colour;
                    en_ax[n_en]  = ax;
                end
                $display("tick %0d draw_en opcode=%0d clear=%0b colour=%h ax=%h", t, opcode,
                         screen_clear, colour, ax);
                n_en++;
                cd = DONE_DLY + 1;
            end
            if (swap_buffer) begin
                if (swap_tick < 0) swap_tick = t;
                swap_cnt++;
                $display("tick %0d swap_buffer front=%0d back_addr=%h", t, front_idx, back_buf_addr);
            end
            if (frame_dropped) begin
                drop_cnt++;
                $display("tick %0d frame_dropped", t);
            end
            frame_start = (t == inj_a) || (t == inj_b);
            draw_done   = (t == spur_tick);
            if (cd > 0) begin
                cd--;
                if (cd == 0) draw_done = 1'b1;
            end
            vga_blank_n = (t < blank_tick);
            if (swap_tick >= 0 && t >= swap_tick + 3) break;
        end
        frame_start = 1'b0;
        draw_done   = 1'b0;
        vga_blank_n = 1'b1;
        timed_out   = (swap_tick < 0);
    endtask

    task automatic test_reset();
        checks++; if (back_buf_addr !== 32'h0012C000) begin errors++; $display("FAIL reset_addr got %h want 0012c000", back_buf_addr); end
        checks++; if (front_idx !== 2'd0) begin errors++; $display("FAIL reset_front got %0d want 0", front_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({draw_en, screen_clear, swap_buffer, frame_dropped} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b want 0000", {draw_en, screen_clear, swap_buffer, frame_dropped}); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", frame_count); end
        checks++; if ({opcode, ax, colour, prim_idx} !== '0) begin errors++; $display("FAIL reset_cmd got op=%0d ax=%h col=%h idx=%0d want zeros", opcode, ax, colour, prim_idx); end
        checks++; if (back_buf_addr_3 !== 32'h0012C000) begin errors++; $display("FAIL reset_addr3 got %h want 0012c000", back_buf_addr_3); end
        $display("reset checked: addr=%h front=%0d", back_buf_addr, front_idx);
    endtask

    task automatic test_clear_prims_vsync();
        clear_en = 1'b1; clear_colour = 32'h00FF_00FF; prim_count = 5'd2; vsync_swap = 1'b1;
        run_frame(30, -1, -1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL cpv_timeout got no swap want swap"); end
        checks++; if (n_en !== 3) begin errors++; $display("FAIL cpv_draw_count got %0d want 3", n_en); end
        checks++; if ({en_op[0], en_op[1], en_op[2]} !== 12'h011) begin errors++; $display("FAIL cpv_opcodes got %h want 011", {en_op[0], en_op[1], en_op[2]}); end
        checks++; if ({en_clr[0], en_clr[1], en_clr[2]} !== 3'b100) begin errors++; $display("FAIL cpv_screen_clear got %b want 100", {en_clr[0], en_clr[1], en_clr[2]}); end
        checks++; if (en_col[0] !== 32'h00FF00FF) begin errors++; $display("FAIL cpv_clear_colour got %h want 00ff00ff", en_col[0]); end
        checks++; if ({en_ax[1], en_ax[2]} !== {16'h0100, 16'h0101}) begin errors++; $display("FAIL cpv_prim_ax got %h/%h want 0100/0101", en_ax[1], en_ax[2]); end
        checks++; if (en_col[2] !== 32'hC0DE0001) begin errors++; $display("FAIL cpv_prim_colour got %h want c0de0001", en_col[2]); end
        checks++; if (swap_tick !== 32) begin errors++; $display("FAIL cpv_swap_tick got %0d want 32", swap_tick); end
        checks++; if (swap_cnt !== 1) begin errors++; $display("FAIL cpv_swap_width got %0d want 1", swap_cnt); end
        checks++; if (back_buf_addr !== 32'h0) begin errors++; $display("FAIL cpv_addr got %h want 00000000", back_buf_addr); end
        checks++; if (front_idx !== 2'd1) begin errors++; $display("FAIL cpv_front got %0d want 1", front_idx); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL cpv_count got %0d want 1", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cpv_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_rotation3();
        logic [31:0] exp_addr [4] = '{32'h00258000, 32'h00000000, 32'h0012C000, 32'h00258000};
        logic [1:0]  exp_front [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        clear_en = 1'b0; prim_count = 5'd0; vsync_swap = 1'b0;
        for (int k = 0; k < 4; k++) begin
            frame_start_3 = 1'b1;
            tick();
            frame_start_3 = 1'b0;
            tick();
            checks++; if (swap_buffer_3 !== 1'b1) begin errors++; $display("FAIL rot3_swap[%0d] got %b want 1", k, swap_buffer_3); end
            tick();
            $display("rot3 frame %0d back_addr=%h front=%0d", k, back_buf_addr_3, front_idx_3);
            checks++; if (back_buf_addr_3 !== exp_addr[k]) begin errors++; $display("FAIL rot3_addr[%0d] got %h want %h", k, back_buf_addr_3, exp_addr[k]); end
            checks++; if (front_idx_3 !== exp_front[k]) begin errors++; $display("FAIL rot3_front[%0d] got %0d want %0d", k, front_idx_3, exp_front[k]); end
        end
        checks++; if (frame_count_3 !== 16'd4) begin errors++; $display("FAIL rot3_count got %0d want 4", frame_count_3); end
    endtask

    task automatic test_dropped();
        clear_en = 1'b0; prim_count = 5'd1; vsync_swap = 1'b0;
        // tick 5 lands in PRIM_WAIT, tick 9 in SWAP
        run_frame(0, 5, 9, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL drop_timeout got no swap want swap"); end
        checks++; if (drop_cnt !== 2) begin errors++; $display("FAIL drop_pulses got %0d want 2", drop_cnt); end
        checks++; if (swap_tick !== 10) begin errors++; $display("FAIL drop_swap_tick got %0d want 10", swap_tick); end
        checks++; if (n_en !== 1) begin errors++; $display("FAIL drop_draw_count got %0d want 1", n_en); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL drop_count got %0d want 2", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_spurious_done();
        clear_en = 1'b0; prim_count = 5'd1; vsync_swap = 1'b0;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        tick();
        checks++; if ({busy, draw_en, swap_buffer} !== 3'b000) begin errors++; $display("FAIL spur_idle got %b want 000", {busy, draw_en, swap_buffer}); end
        // tick 2 lands in PRIM_ISSUE; the real completion follows at tick 8
        run_frame(0, -1, -1, 2);
        checks++; if (timed_out) begin errors++; $display("FAIL spur_timeout got no swap want swap"); end
        checks++; if (swap_tick !== 10) begin errors++; $display("FAIL spur_swap_tick got %0d want 10", swap_tick); end
        checks++; if (n_en !== 1) begin errors++; $display("FAIL spur_draw_count got %0d want 1", n_en); end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL spur_count got %0d want 3", frame_count); end
    endtask

    task automatic test_reset_midframe();
        clear_en = 1'b1; clear_colour = 32'h1234_5678; prim_count = 5'd1; vsync_swap = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b want 1", busy); end
        reset = 1'b1;
        tick();
        $display("reset mid-frame: busy=%b addr=%h", busy, back_buf_addr);
        checks++; if ({busy, draw_en, swap_buffer, screen_clear} !== 4'b0000) begin errors++; $display("FAIL rmid_state got %b want 0000", {busy, draw_en, swap_buffer, screen_clear}); end
        checks++; if (back_buf_addr !== 32'h0012C000) begin errors++; $display("FAIL rmid_addr got %h want 0012c000", back_buf_addr); end
        checks++; if ({front_idx, frame_count} !== 18'd0) begin errors++; $display("FAIL rmid_front_count got %0d/%0d want 0/0", front_idx, frame_count); end
        reset = 1'b0;
        tick();
        run_frame(0, -1, -1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL rmid_timeout got no swap want swap"); end
        checks++; if (n_en !== 2) begin errors++; $display("FAIL rmid_draw_count got %0d want 2", n_en); end
        checks++; if (en_col[0] !== 32'h12345678) begin errors++; $display("FAIL rmid_clear_colour got %h want 12345678", en_col[0]); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL rmid_count got %0d want 1", frame_count); end
        checks++; if (back_buf_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr_after got %h want 00000000", back_buf_addr); end
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; frame_start_3 = 1'b0; clear_en = 1'b0;
        clear_colour = '0; vsync_swap = 1'b0; vga_blank_n = 1'b1; draw_done = 1'b0;
        prim_count = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_clear_prims_vsync();
        test_rotation3();
        test_dropped();
        test_spurious_done();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
